power_seq_ctrl: RTL
===================

Name: power_seq_ctrl

Overview:
Multi-rail power sequencer. It enables NUM_RAILS supply domains strictly in ascending order, and advances to the next rail only after the current rail's power_good has stayed stable for STABLE_CYCLES. It powers down in reverse order, monitors every enabled rail for dropout, and latches a fault that shuts all rails off. It sits above the per-rail power-on qualifiers and drives their enable inputs.

Parameters:
NUM_RAILS, 4, number of sequenced rails (2..8)
STABLE_CYCLES, 30, consecutive sampled-high cycles of rail_pg[i] required to qualify rail i
TIMEOUT_CYCLES, 200, cycles allowed from rail_en[i] rise to qualification before fault
OFF_WAIT_CYCLES, 50, maximum cycles to wait for rail_pg[i] low during power-down

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  power-up request, sampled in IDLE only
stop  input  1  power-down request, sampled in UP and ON
clear_fault  input  1  leaves FAULT, sampled in FAULT only
rail_pg  input  NUM_RAILS  per-rail power_good, bit i belongs to rail i
rail_en  output  NUM_RAILS  per-rail enable, registered
all_good  output  1  high only in ON
busy  output  1  high in UP or DOWN
fault  output  1  high in FAULT
fault_rail  output  $clog2(NUM_RAILS)  index of the offending rail, valid while fault=1

Behaviour:
- Reset (async, immediate): state=IDLE, rail_en=0, all_good=0, busy=0, fault=0, fault_rail=0, idx=0, all counters=0.
- All outputs are registered. Counter widths are $clog2(max+1). Counters saturate and never wrap.
- States: IDLE, UP, ON, DOWN, FAULT.

IDLE:
- Edge sampling start=1 and stop=0: go to UP with idx=0. rail_en[0] rises on that same edge.
- start and stop both high: stop wins, stay in IDLE.

UP:
- stab_cnt increments on each edge with rail_pg[idx]=1 and clears to 0 on any edge with rail_pg[idx]=0.
- to_cnt increments every edge since rail_en[idx] rose.
- Edge on which stab_cnt would reach STABLE_CYCLES:
  - if idx<NUM_RAILS-1: idx++, rail_en[idx] rises on that edge, both counters clear.
  - else: go to ON.
- to_cnt reaches TIMEOUT_CYCLES before qualification: go to FAULT with fault_rail=idx.
- Any rail j<idx sampled with rail_pg[j]=0: go to FAULT with fault_rail=lowest such j.
- stop=1: go to DOWN, beginning at the current idx.

ON:
- all_good=1.
- Any rail sampled with rail_pg=0: go to FAULT with fault_rail=lowest such index. all_good falls on the same edge.
- stop=1: go to DOWN with idx=NUM_RAILS-1. all_good falls on the same edge.
- start is ignored.

DOWN:
- On entry edge, rail_en[idx] falls and off_cnt clears.
- Advance when rail_pg[idx] is sampled 0 or off_cnt reaches OFF_WAIT_CYCLES. A slow discharge is not a fault.
- Advancing: if idx>0, idx--, clear rail_en[idx] on that edge. If idx==0, go to IDLE.
- Dropout is not monitored in DOWN.
- start and stop are ignored.

FAULT:
- rail_en=0, fault=1, and fault_rail are all set on the entering edge.
- clear_fault=1: go to IDLE with fault=0 and fault_rail=0.
- All other inputs are ignored.

Priority in one cycle: fault conditions > timeout > stop > qualification advance.

reset asserted mid-sequence: all enables drop asynchronously, with no reverse ordering.

Test Plan:
Bench convention: a rail model drives rail_pg[i] high 5 cycles after rail_en[i] rises and low 3 cycles after it falls. Stimulus changes on the falling edge. Defaults apply unless stated.
1. Full power-up: pulse start at edge 0 -> rail_en[0]=1 at edge 0. Each rail_en[i+1] rises 34 edges after rail_en[i]. all_good=1 at edge 136 (4 rails x 34). fault stays 0 throughout.
2. Glitch restart: rail_pg[1] dropped for 1 cycle 20 cycles into qualification -> stab_cnt clears and rail_en[2] is delayed by 21 cycles. No fault.
3. Timeout: rail_pg[2] held 0 -> FAULT exactly 200 edges after rail_en[2] rose. fault_rail=2, rail_en=0 on the same edge. clear_fault -> IDLE.
4. Dropout in ON: rail_pg[1] and rail_pg[3] pulled low on the same edge -> FAULT with fault_rail=1. all_good=0 and rail_en=0 on that edge.
5. Ordered power-down: stop in ON -> rail_en[3] falls first, then rails 2, 1, 0 each 3 edges apart -> IDLE. With rail_pg[2] stuck high, rail 2 waits exactly 50 edges and the sequence continues.
6. Corner cases:
   - start and stop together in IDLE -> stay in IDLE.
   - stop during UP at idx=1 -> DOWN clears rail_en[1], then rail_en[0].
   - reset asserted mid-UP -> rail_en=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/power_seq_ctrl.sv
// Multi-rail power sequencer: ordered bring-up with per-rail qualification,
// reverse-order shutdown, and dropout/timeout fault latching.
module power_seq_ctrl #(
    parameter int NUM_RAILS       = 4,
    parameter int STABLE_CYCLES   = 30,
    parameter int TIMEOUT_CYCLES  = 200,
    parameter int OFF_WAIT_CYCLES = 50
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         clear_fault,
    input  logic [NUM_RAILS-1:0]         rail_pg,
    output logic [NUM_RAILS-1:0]         rail_en,
    output logic                         all_good,
    output logic                         busy,
    output logic                         fault,
    output logic [$clog2(NUM_RAILS)-1:0] fault_rail
);

    localparam int IW = $clog2(NUM_RAILS);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int OW = $clog2(OFF_WAIT_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_UP    = 3'd1;
    localparam logic [2:0] S_ON    = 3'd2;
    localparam logic [2:0] S_DOWN  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_RAILS - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [OW-1:0] OFF_LAST  = OW'(OFF_WAIT_CYCLES - 1);
    localparam logic [OW-1:0] OFF_MAX   = OW'(OFF_WAIT_CYCLES);

    logic [2:0]           r_state;
    logic [IW-1:0]        r_idx;
    logic [SW-1:0]        r_stab_cnt;
    logic [TW-1:0]        r_to_cnt;
    logic [OW-1:0]        r_off_cnt;
    logic [NUM_RAILS-1:0] r_rail_en;
    logic                 r_all_good;
    logic                 r_busy;
    logic                 r_fault;
    logic [IW-1:0]        r_fault_rail;

    logic [2:0]           w_nxt_state;
    logic [IW-1:0]        w_nxt_idx;
    logic [SW-1:0]        w_nxt_stab;
    logic [TW-1:0]        w_nxt_to;
    logic [OW-1:0]        w_nxt_off;
    logic [NUM_RAILS-1:0] w_nxt_en;
    logic [IW-1:0]        w_nxt_frail;

    logic [NUM_RAILS-1:0] w_below_bad;
    logic [NUM_RAILS-1:0] w_any_bad;
    logic                 w_pg_cur;
    logic [IW-1:0]        w_idx_inc;
    logic [IW-1:0]        w_idx_dec;

    // Lowest set bit wins, so the earliest rail in the chain is reported.
    function automatic logic [IW-1:0] lowest_set(input logic [NUM_RAILS-1:0] m);
        lowest_set = '0;
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = IW'(i);
        end
    endfunction

    always_comb begin
        w_below_bad = '0;
        for (int i = 0; i < NUM_RAILS; i++) begin
            w_below_bad[i] = ~rail_pg[i] && (IW'(i) < r_idx);
        end
    end

    assign w_any_bad = ~rail_pg;
    assign w_pg_cur  = rail_pg[r_idx];
    assign w_idx_inc = r_idx + 1'b1;
    assign w_idx_dec = r_idx - 1'b1;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_stab  = r_stab_cnt;
        w_nxt_to    = r_to_cnt;
        w_nxt_off   = r_off_cnt;
        w_nxt_en    = r_rail_en;
        w_nxt_frail = r_fault_rail;
        unique case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_nxt_state = S_UP;
                    w_nxt_idx   = '0;
                    w_nxt_stab  = '0;
                    w_nxt_to    = '0;
                    w_nxt_en    = '0;
                    w_nxt_en[0] = 1'b1;
                end
            end
            S_UP: begin
                if (|w_below_bad) begin
                    w_nxt_state = S_FAULT;
                    w_nxt_frail = lowest_set(w_below_bad);
                    w_nxt_en    = '0;
                end else if (r_to_cnt == TO_LAST) begin
                    w_nxt_state = S_FAULT;
                    w_nxt_frail = r_idx;
                    w_nxt_en    = '0;
                end else if (stop) begin
                    w_nxt_state     = S_DOWN;
                    w_nxt_en[r_idx] = 1'b0;
                    w_nxt_off       = '0;
                end else begin
                    if (r_to_cnt != TO_MAX) w_nxt_to = r_to_cnt + 1'b1;
                    if (!w_pg_cur) begin
                        w_nxt_stab = '0;
                    end else if (r_stab_cnt == STAB_LAST) begin
                        w_nxt_stab = '0;
                        w_nxt_to   = '0;
                        if (r_idx == IDX_LAST) begin
                            w_nxt_state = S_ON;
                        end else begin
                            w_nxt_idx           = w_idx_inc;
                            w_nxt_en[w_idx_inc] = 1'b1;
                        end
                    end else if (r_stab_cnt != STAB_MAX) begin
                        w_nxt_stab = r_stab_cnt + 1'b1;
                    end
                end
            end
            S_ON: begin
                if (|w_any_bad) begin
                    w_nxt_state = S_FAULT;
                    w_nxt_frail = lowest_set(w_any_bad);
                    w_nxt_en    = '0;
                end else if (stop) begin
                    w_nxt_state        = S_DOWN;
                    w_nxt_idx          = IDX_LAST;
                    w_nxt_en[IDX_LAST] = 1'b0;
                    w_nxt_off          = '0;
                end
            end
            S_DOWN: begin
                // A rail that never discharges is skipped after the wait, not faulted.
                if (!w_pg_cur || r_off_cnt == OFF_LAST) begin
                    w_nxt_off = '0;
                    if (r_idx == '0) begin
                        w_nxt_state = S_IDLE;
                        w_nxt_en    = '0;
                    end else begin
                        w_nxt_idx           = w_idx_dec;
                        w_nxt_en[w_idx_dec] = 1'b0;
                    end
                end else if (r_off_cnt != OFF_MAX) begin
                    w_nxt_off = r_off_cnt + 1'b1;
                end
            end
            S_FAULT: begin
                w_nxt_en = '0;
                if (clear_fault) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_frail = '0;
                    w_nxt_idx   = '0;
                    w_nxt_stab  = '0;
                    w_nxt_to    = '0;
                    w_nxt_off   = '0;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_en    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_stab_cnt   <= '0;
            r_to_cnt     <= '0;
            r_off_cnt    <= '0;
            r_rail_en    <= '0;
            r_all_good   <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_rail <= '0;
        end else begin
            r_state      <= w_nxt_state;
            r_idx        <= w_nxt_idx;
            r_stab_cnt   <= w_nxt_stab;
            r_to_cnt     <= w_nxt_to;
            r_off_cnt    <= w_nxt_off;
            r_rail_en    <= w_nxt_en;
            r_all_good   <= (w_nxt_state == S_ON);
            r_busy       <= (w_nxt_state == S_UP) || (w_nxt_state == S_DOWN);
            r_fault      <= (w_nxt_state == S_FAULT);
            r_fault_rail <= w_nxt_frail;
        end
    end

    assign rail_en    = r_rail_en;
    assign all_good   = r_all_good;
    assign busy       = r_busy;
    assign fault      = r_fault;
    assign fault_rail = r_fault_rail;

endmodule
